uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter (state machine, baud counter, frame counter, PISO) among NUM_REQ byte sources. It accepts one byte from the winning requester and issues a single-cycle load pulse with the data to the transmitter. It then waits for the transmitter's end-of-frame pulse and an optional inter-frame gap before arbitrating again. It sits between the system's message producers and the UART TX path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; matches the transmitter word length
GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next grant (0 = no gap state)
TIMEOUT_CYCLES, 65535, watchdog limit in WAIT_DONE; used only with UART_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  request per source; held high until granted
req_data  in  NUM_REQ*DATA_W  byte per source; slice i = bits [i*DATA_W +: DATA_W]; stable while req[i]=1
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: byte from that source accepted
tx_load  out  1  1-cycle load pulse to the UART TX
tx_data  out  DATA_W  byte to transmit; valid with tx_load, held until next load
tx_busy  in  1  transmitter frame in progress
tx_done  in  1  1-cycle end-of-frame pulse from the transmitter
arb_busy  out  1  high whenever state != IDLE
cur_id  out  $clog2(NUM_REQ)  index of last granted source
timeout_err  out  1  sticky watchdog flag (see Optional Feature)

Behaviour:
- Reset (sync, high): state=IDLE, gnt=0, tx_load=0, tx_data=0, cur_id=0, rr_ptr=0, gap/timeout counters=0, timeout_err=0. Reset overrides all activity, including mid-frame. Any load already issued is abandoned; the arbiter does not re-send it.
- States: IDLE, WAIT_DONE, GAP.
- IDLE: if |req and !tx_busy:
  - Winner = first set req[i] scanning from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
  - At the next edge: gnt[winner]=1, tx_load=1, tx_data=req_data slice, cur_id=winner, rr_ptr=(winner+1) mod NUM_REQ, state=WAIT_DONE.
  - Latency from req sampled to tx_load high = 1 clock.
- If tx_busy=1 in IDLE, no grant occurs. req is ignored.
- gnt and tx_load are high for exactly one cycle. They are deasserted in the first WAIT_DONE cycle.
- WAIT_DONE: on tx_done go to GAP if GAP_CYCLES>0, else to IDLE. tx_done while IDLE/GAP is ignored.
- GAP: count GAP_CYCLES clocks, then go to IDLE.
- Minimum spacing tx_done -> next tx_load is GAP_CYCLES+2 clocks. The IDLE cycle is always visited, so a req arriving with tx_done is granted from IDLE.
- A requester deasserting req before gnt withdraws its request with no side effects. After gnt, the source drops req or presents its next byte; the next byte competes normally.
- Fairness: with all req high, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- rr_ptr advances only on a grant.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without tx_done, the arbiter goes to IDLE and sets timeout_err=1 (sticky until rst).
  - Arbitration then continues normally.
- Not defined: no counter is built, timeout_err is tied to 0, and WAIT_DONE waits indefinitely for tx_done.

Test Plan:
- Reset, req=4'b0001, data0=8'h05 -> one clock later gnt=0001, tx_load=1, tx_data=8'h05, cur_id=0; after tx_done pulse, arb_busy=0 next clock.
- req=4'b0110 simultaneous, rr_ptr=0, data1=8'hA1, data2=8'hB2 -> first grant to 1 (tx_data=A1); after tx_done, grant to 2 (tx_data=B2).
- All four req held high, 8 frames -> grant order 0,1,2,3,0,1,2,3. Exactly one gnt bit per load, never two.
- GAP_CYCLES=3, req continuously high -> tx_done to next tx_load = 5 clocks. A new req arriving on the tx_done cycle waits out the gap.
- rst asserted in WAIT_DONE -> next clock state IDLE, all outputs at reset values. A later tx_done is ignored, and no tx_load occurs without req.
- UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no tx_done after load -> after 16 WAIT_DONE clocks timeout_err=1, arb_busy=0, and a pending req is granted next. Without the macro, timeout_err stays 0 and arb_busy stays 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter
// among NUM_REQ byte sources. It hands one byte to the transmitter, then
// waits for end-of-frame and an optional idle gap before arbitrating again.
// Optional build macro: UART_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog that
// sets a sticky timeout_err flag and returns to IDLE.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        tx_load,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    input  logic                        tx_done,
    output logic                        arb_busy,
    output logic [$clog2(NUM_REQ)-1:0]  cur_id,
    output logic                        timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                tx_load_q, tx_load_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic                win_found;
    logic [ID_W-1:0]     win_id;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                err_q, err_d;
`endif

    // Pick the first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/WAIT_DONE/GAP FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        tx_load_d = 1'b0;
        tx_data_d = tx_data_q;
        cur_id_d  = cur_id_q;
        rr_ptr_d  = rr_ptr_q;
        gap_cnt_d = gap_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found && !tx_busy) begin
                    gnt_d[win_id] = 1'b1;
                    tx_load_d     = 1'b1;
                    tx_data_d     = req_data[win_id*DATA_W +: DATA_W];
                    cur_id_d      = win_id;
                    rr_ptr_d      = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    state_d       = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_d      = '0;
`endif
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d   = IDLE;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            tx_load_q <= 1'b0;
            tx_data_q <= '0;
            cur_id_q  <= '0;
            rr_ptr_q  <= '0;
            gap_cnt_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            tx_load_q <= tx_load_d;
            tx_data_q <= tx_data_d;
            cur_id_q  <= cur_id_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign tx_load  = tx_load_q;
    assign tx_data  = tx_data_q;
    assign cur_id   = cur_id_q;
    assign arb_busy = (state_q != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
